// File: rtl/bbox_setup_if.sv
// Bundle between a triangle source, bbox_setup and the bounding-box iterator.
// The master modport drives triangles and the iterator's status; the slave modport is the setup stage.
interface bbox_setup_if #(parameter int XLEN = 15);
  // Handshake: a triangle transfers on the rising edge where i_valid && o_ready;
  // the fields are sampled only on that edge and may change freely otherwise.
  logic              i_valid;
  logic              o_ready;
  logic signed [XLEN:0] i_x0, i_y0, i_x1, i_y1, i_x2, i_y2;
  logic signed [XLEN:0] i_sc_x0, i_sc_x1, i_sc_y0, i_sc_y1;
  logic signed [XLEN:0] o_bbx0, o_bbx1, o_bby0, o_bby1;
  logic              o_iter_write;
  logic              o_iter_enable;
  logic              i_iter_done;
  logic              i_stall;
  logic              o_busy;
  logic              o_culled;

  modport master (
    output i_valid, i_x0, i_y0, i_x1, i_y1, i_x2, i_y2,
    output i_sc_x0, i_sc_x1, i_sc_y0, i_sc_y1, i_iter_done, i_stall,
    input  o_ready, o_bbx0, o_bbx1, o_bby0, o_bby1,
    input  o_iter_write, o_iter_enable, o_busy, o_culled
  );

  modport slave (
    input  i_valid, i_x0, i_y0, i_x1, i_y1, i_x2, i_y2,
    input  i_sc_x0, i_sc_x1, i_sc_y0, i_sc_y1, i_iter_done, i_stall,
    output o_ready, o_bbx0, o_bbx1, o_bby0, o_bby1,
    output o_iter_write, o_iter_enable, o_busy, o_culled
  );
endinterface

// File: rtl/bbox_setup.sv
// Triangle bounding-box setup: min/max, scissor clamp and cull, then iterator load and drive.
// Macro BBOX_SETUP_SCISSOR_EN enables scissor clamping/culling; otherwise the box is min/max only.
module bbox_setup #(
  parameter int XLEN = 15
) (
  input  logic         i_clk,
  input  logic         i_reset,
  bbox_setup_if.slave  bus,
  output logic [2:0]   o_state
);

  typedef logic signed [XLEN:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MINMAX = 3'd1,
    S_CLIP   = 3'd2,
    S_WRITE  = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  state_t state_q, state_d;

  coord_t x_q [3];
  coord_t y_q [3];
  coord_t minx_q, maxx_q, miny_q, maxy_q;
  coord_t bbx0_q, bbx1_q, bby0_q, bby1_q;
  logic   empty_q;
  logic   done_armed_q;

  coord_t clip_x0, clip_x1, clip_y0, clip_y1;
  logic   clip_empty;
  logic   iter_enable;

  function automatic coord_t smin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t smax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

`ifdef BBOX_SETUP_SCISSOR_EN
  coord_t sc_x0_q, sc_x1_q, sc_y0_q, sc_y1_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sc_x0_q <= '0;
      sc_x1_q <= '0;
      sc_y0_q <= '0;
      sc_y1_q <= '0;
    end else if (state_q == S_IDLE && bus.i_valid) begin
      sc_x0_q <= bus.i_sc_x0;
      sc_x1_q <= bus.i_sc_x1;
      sc_y0_q <= bus.i_sc_y0;
      sc_y1_q <= bus.i_sc_y1;
    end
  end

  // An inverted scissor yields an inverted box, so it culls through the same test.
  always_comb begin
    clip_x0    = smax(minx_q, sc_x0_q);
    clip_x1    = smin(maxx_q, sc_x1_q);
    clip_y0    = smax(miny_q, sc_y0_q);
    clip_y1    = smin(maxy_q, sc_y1_q);
    clip_empty = (clip_x0 > clip_x1) || (clip_y0 > clip_y1);
  end
`else
  always_comb begin
    clip_x0    = minx_q;
    clip_x1    = maxx_q;
    clip_y0    = miny_q;
    clip_y1    = maxy_q;
    clip_empty = 1'b0;
  end
`endif

  // The iterator's done flag is stale until it has stepped once under this load.
  always_comb begin
    iter_enable = 1'b0;
    if (state_q == S_RUN)
      iter_enable = !bus.i_stall && !(done_armed_q && bus.i_iter_done);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.i_valid) state_d = S_MINMAX;
      S_MINMAX: state_d = S_CLIP;
      S_CLIP:   state_d = S_WRITE;
      S_WRITE:  state_d = empty_q ? S_IDLE : S_RUN;
      S_RUN:    if (done_armed_q && bus.i_iter_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_q          <= '{default: '0};
      y_q          <= '{default: '0};
      minx_q       <= '0;
      maxx_q       <= '0;
      miny_q       <= '0;
      maxy_q       <= '0;
      bbx0_q       <= '0;
      bbx1_q       <= '0;
      bby0_q       <= '0;
      bby1_q       <= '0;
      empty_q      <= 1'b0;
      done_armed_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.i_valid) begin
          x_q[0] <= bus.i_x0;
          x_q[1] <= bus.i_x1;
          x_q[2] <= bus.i_x2;
          y_q[0] <= bus.i_y0;
          y_q[1] <= bus.i_y1;
          y_q[2] <= bus.i_y2;
        end
        S_MINMAX: begin
          minx_q <= smin(smin(x_q[0], x_q[1]), x_q[2]);
          maxx_q <= smax(smax(x_q[0], x_q[1]), x_q[2]);
          miny_q <= smin(smin(y_q[0], y_q[1]), y_q[2]);
          maxy_q <= smax(smax(y_q[0], y_q[1]), y_q[2]);
        end
        S_CLIP: begin
          bbx0_q  <= clip_x0;
          bbx1_q  <= clip_x1;
          bby0_q  <= clip_y0;
          bby1_q  <= clip_y1;
          empty_q <= clip_empty;
        end
        S_WRITE: done_armed_q <= 1'b0;
        S_RUN:   if (iter_enable) done_armed_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_iter_write  = (state_q == S_WRITE) && !empty_q;
  assign bus.o_culled      = (state_q == S_WRITE) && empty_q;
  assign bus.o_iter_enable = iter_enable;
  assign bus.o_bbx0        = bbx0_q;
  assign bus.o_bbx1        = bbx1_q;
  assign bus.o_bby0        = bby0_q;
  assign bus.o_bby1        = bby1_q;
  assign o_state           = state_q;

endmodule
